// File: rtl/mandel_dispatch_scheduler.sv
// Round-robin dispatch of Mandelbrot pixel jobs over NUM_ENGINES iteration engines,
// with in-order (raster) retirement and sof/eol/frame_done framing toward the packer.
module mandel_dispatch_scheduler #(
    parameter int NUM_ENGINES = 4,
    parameter int X_SIZE      = 640,
    parameter int Y_SIZE      = 480
) (
    input  logic                     aclk,
    input  logic                     reset,
    input  logic                     run,
    output logic [NUM_ENGINES-1:0]   eng_start,
    output logic [9:0]               eng_x,
    output logic [8:0]               eng_y,
    input  logic [NUM_ENGINES-1:0]   eng_done,
    input  logic [8*NUM_ENGINES-1:0] eng_iter,
    output logic [NUM_ENGINES-1:0]   eng_ack,
    output logic [7:0]               out_iter,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_sof,
    output logic                     out_eol,
    output logic                     frame_done
);

    localparam int PW = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } slot_t;

    slot_t         slot [NUM_ENGINES];
    logic [PW-1:0] dp;
    logic [PW-1:0] rp;
    logic [9:0]    dx;
    logic [8:0]    dy;
    logic [9:0]    rx;
    logic [8:0]    ry;
    logic          dispatch;
    logic          retire;
    logic          rx_last;
    logic          ry_last;
    logic [7:0]    iter_arr [NUM_ENGINES];

    for (genvar g = 0; g < NUM_ENGINES; g++) begin : g_iter
        assign iter_arr[g] = eng_iter[8*g +: 8];
    end

    // Dispatch looks only at registered slot state, so a slot freed this cycle
    // cannot be restarted until the next one.
    assign dispatch  = run && (slot[dp] == IDLE);
    assign out_valid = (slot[rp] == BUSY) && eng_done[rp];
    assign retire    = out_valid && out_ready && !reset;
    assign out_iter  = iter_arr[rp];
    assign rx_last   = (rx == 10'(X_SIZE - 1));
    assign ry_last   = (ry == 9'(Y_SIZE - 1));
    assign out_sof   = out_valid && (rx == 10'd0) && (ry == 9'd0);
    assign out_eol   = out_valid && rx_last;

    always_comb begin
        eng_ack = '0;
        if (retire) begin
            eng_ack[rp] = 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            for (int i = 0; i < NUM_ENGINES; i++) begin
                slot[i] <= IDLE;
            end
            dp         <= '0;
            rp         <= '0;
            dx         <= '0;
            dy         <= '0;
            rx         <= '0;
            ry         <= '0;
            eng_start  <= '0;
            eng_x      <= '0;
            eng_y      <= '0;
            frame_done <= 1'b0;
        end else begin
            eng_start  <= '0;
            frame_done <= 1'b0;

            if (dispatch) begin
                eng_start[dp] <= 1'b1;
                eng_x         <= dx;
                eng_y         <= dy;
                slot[dp]      <= BUSY;
                dp            <= dp + PW'(1);
                if (dx == 10'(X_SIZE - 1)) begin
                    dx <= '0;
                    dy <= (dy == 9'(Y_SIZE - 1)) ? 9'd0 : dy + 9'd1;
                end else begin
                    dx <= dx + 10'd1;
                end
            end

            // Dispatch needs an IDLE slot and retire a BUSY one, so they never
            // touch the same slot in one cycle.
            if (retire) begin
                slot[rp]   <= IDLE;
                rp         <= rp + PW'(1);
                frame_done <= rx_last && ry_last;
                if (rx_last) begin
                    rx <= '0;
                    ry <= ry_last ? 9'd0 : ry + 9'd1;
                end else begin
                    rx <= rx + 10'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mandel_dispatch_scheduler.sv
// Directed bench for mandel_dispatch_scheduler: fill order, out-of-order completion,
// back-pressure, full 8x4 frame with a run pause, and reset with jobs in flight.
module tb_mandel_dispatch_scheduler;

    localparam int NE = 4;
    localparam int XS = 8;
    localparam int YS = 4;

    logic            aclk = 1'b0;
    logic            reset = 1'b1;
    logic            run = 1'b0;
    logic            out_ready = 1'b0;
    logic [NE-1:0]   eng_start;
    logic [9:0]      eng_x;
    logic [8:0]      eng_y;
    logic [NE-1:0]   eng_done = '0;
    logic [8*NE-1:0] eng_iter = '0;
    logic [NE-1:0]   eng_ack;
    logic [7:0]      out_iter;
    logic            out_valid;
    logic            out_sof;
    logic            out_eol;
    logic            frame_done;

    mandel_dispatch_scheduler #(
        .NUM_ENGINES(NE),
        .X_SIZE     (XS),
        .Y_SIZE     (YS)
    ) dut (
        .aclk      (aclk),
        .reset     (reset),
        .run       (run),
        .eng_start (eng_start),
        .eng_x     (eng_x),
        .eng_y     (eng_y),
        .eng_done  (eng_done),
        .eng_iter  (eng_iter),
        .eng_ack   (eng_ack),
        .out_iter  (out_iter),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sof   (out_sof),
        .out_eol   (out_eol),
        .frame_done(frame_done)
    );

    always #5 aclk = ~aclk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        if (obs !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, want, $time);
        end
    endtask

    task automatic cyc();
        @(posedge aclk);
        #1;
    endtask

    // Engine model state for the frame phase
    int         cnt     [NE];
    bit         busy_m  [NE];
    bit         done_m  [NE];
    logic [7:0] iter_m  [NE];
    int         exp_dx, exp_dy, exp_dp, exp_rx, exp_ry, exp_rp;
    int         retired, dispatched, fd_count;
    bit         force_ready;

    function automatic logic [7:0] iterf(input int x, input int y);
        return 8'(y * XS + x + 3);
    endfunction

    task automatic step();
        bit            hs;
        bit            fd_want;
        bit            start_want;
        int            acked;
        logic [NE-1:0] oh_rp;
        logic [NE-1:0] oh_dp;
        oh_rp      = NE'(1) << exp_rp;
        oh_dp      = NE'(1) << exp_dp;
        hs         = done_m[exp_rp] && out_ready;
        start_want = run && !busy_m[exp_dp];
        fd_want    = 1'b0;
        acked      = -1;
        check("out_valid", 32'(out_valid), 32'(done_m[exp_rp]));
        if (hs) begin
            check("ret_iter", 32'(out_iter), 32'(iterf(exp_rx, exp_ry)));
            check("ret_sof", 32'(out_sof), 32'(exp_rx == 0 && exp_ry == 0));
            check("ret_eol", 32'(out_eol), 32'(exp_rx == XS - 1));
            check("ret_ack", 32'(eng_ack), 32'(oh_rp));
            fd_want = (exp_rx == XS - 1) && (exp_ry == YS - 1);
            acked   = exp_rp;
            if (exp_rx == XS - 1) begin
                exp_rx = 0;
                exp_ry = (exp_ry == YS - 1) ? 0 : exp_ry + 1;
            end else begin
                exp_rx++;
            end
            exp_rp = (exp_rp + 1) % NE;
            retired++;
        end else begin
            check("no_ack", 32'(eng_ack), 32'(0));
        end
        cyc();
        check("frame_done", 32'(frame_done), 32'(fd_want));
        if (frame_done) fd_count++;
        check("eng_start", 32'(eng_start), start_want ? 32'(oh_dp) : 32'(0));
        if (acked >= 0) begin
            busy_m[acked] = 1'b0;
            done_m[acked] = 1'b0;
        end
        for (int i = 0; i < NE; i++) begin
            if (busy_m[i] && !done_m[i]) begin
                cnt[i]--;
                if (cnt[i] == 0) done_m[i] = 1'b1;
            end
        end
        if (start_want) begin
            check("start_x", 32'(eng_x), 32'(exp_dx));
            check("start_y", 32'(eng_y), 32'(exp_dy));
            busy_m[exp_dp] = 1'b1;
            done_m[exp_dp] = 1'b0;
            cnt[exp_dp]    = int'($urandom_range(1, 6));
            iter_m[exp_dp] = iterf(exp_dx, exp_dy);
            if (exp_dx == XS - 1) begin
                exp_dx = 0;
                exp_dy = (exp_dy == YS - 1) ? 0 : exp_dy + 1;
            end else begin
                exp_dx++;
            end
            exp_dp = (exp_dp + 1) % NE;
            dispatched++;
        end
        for (int i = 0; i < NE; i++) begin
            eng_done[i]        = done_m[i];
            eng_iter[8*i +: 8] = iter_m[i];
        end
        out_ready = force_ready ? 1'b1 : ($urandom_range(0, 3) != 0);
        #1;
    endtask

    initial begin
        bit dropped;
        int cycles;

        // Fill order from reset, out-of-order completion, back-pressure
        reset = 1'b1; run = 1'b1; out_ready = 1'b0;
        cyc(); cyc();
        check("rst_start", 32'(eng_start), 32'(0));
        check("rst_x", 32'(eng_x), 32'(0));
        check("rst_y", 32'(eng_y), 32'(0));
        check("rst_valid", 32'(out_valid), 32'(0));
        check("rst_sof", 32'(out_sof), 32'(0));
        check("rst_fd", 32'(frame_done), 32'(0));
        reset = 1'b0;
        for (int i = 0; i < NE; i++) begin
            cyc();
            check("fill_start", 32'(eng_start), 32'(1 << i));
            check("fill_x", 32'(eng_x), 32'(i));
            check("fill_y", 32'(eng_y), 32'(0));
        end
        cyc();
        check("full_nostart", 32'(eng_start), 32'(0));
        eng_done = 4'b0100; eng_iter[23:16] = 8'd7;
        #1 check("e2_only_valid", 32'(out_valid), 32'(0));
        cyc();
        check("full_nostart2", 32'(eng_start), 32'(0));
        eng_done = 4'b0110; eng_iter[15:8] = 8'd5;
        #1 check("e12_valid", 32'(out_valid), 32'(0));
        cyc();
        eng_done = 4'b0111; eng_iter[7:0] = 8'd3;
        #1;
        check("e0_valid", 32'(out_valid), 32'(1));
        check("e0_iter", 32'(out_iter), 32'(3));
        check("e0_sof", 32'(out_sof), 32'(1));
        check("e0_eol", 32'(out_eol), 32'(0));
        for (int i = 0; i < 10; i++) begin
            cyc();
            check("hold_valid", 32'(out_valid), 32'(1));
            check("hold_iter", 32'(out_iter), 32'(3));
            check("hold_sof", 32'(out_sof), 32'(1));
            check("hold_ack", 32'(eng_ack), 32'(0));
            check("hold_start", 32'(eng_start), 32'(0));
        end
        out_ready = 1'b1;
        #1 check("ack0", 32'(eng_ack), 32'(4'b0001));
        cyc();
        eng_done[0] = 1'b0;
        #1;
        check("r1_iter", 32'(out_iter), 32'(5));
        check("r1_sof", 32'(out_sof), 32'(0));
        check("r1_ack", 32'(eng_ack), 32'(4'b0010));
        check("r1_start", 32'(eng_start), 32'(0));
        cyc();
        check("re0_start", 32'(eng_start), 32'(4'b0001));
        check("re0_x", 32'(eng_x), 32'(4));
        eng_done[1] = 1'b0;
        #1;
        check("r2_iter", 32'(out_iter), 32'(7));
        check("r2_ack", 32'(eng_ack), 32'(4'b0100));
        cyc();
        check("re1_start", 32'(eng_start), 32'(4'b0010));
        check("re1_x", 32'(eng_x), 32'(5));
        eng_done[2] = 1'b0; out_ready = 1'b0;
        #1 check("e3_wait_valid", 32'(out_valid), 32'(0));

        // Full 8x4 frame with random engine latency and a run pause at (5,1)
        reset = 1'b1; run = 1'b0; force_ready = 1'b0;
        eng_done = '0; eng_iter = '0;
        cyc(); cyc();
        for (int i = 0; i < NE; i++) begin
            cnt[i] = 0; busy_m[i] = 1'b0; done_m[i] = 1'b0; iter_m[i] = '0;
        end
        exp_dx = 0; exp_dy = 0; exp_dp = 0; exp_rx = 0; exp_ry = 0; exp_rp = 0;
        retired = 0; dispatched = 0; fd_count = 0; dropped = 1'b0; cycles = 0;
        reset = 1'b0; run = 1'b1;
        #1;
        while (retired < XS * YS + 1 && cycles < 3000) begin
            step();
            cycles++;
            if (!dropped && dispatched == XS + 5) begin
                dropped = 1'b1;
                run = 1'b0; force_ready = 1'b1;
                for (int i = 0; i < 20; i++) begin
                    step();
                    cycles++;
                end
                check("pause_retired", 32'(retired), 32'(XS + 5));
                run = 1'b1; force_ready = 1'b0;
            end
        end
        check("frame_retired", 32'(retired), 32'(XS * YS + 1));
        check("fd_pulses", 32'(fd_count), 32'(1));

        // Reset with three jobs in flight and stale done inputs
        reset = 1'b1; run = 1'b0; out_ready = 1'b0; eng_done = '0;
        cyc(); cyc();
        reset = 1'b0; run = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("f3_start", 32'(eng_start), 32'(1 << i));
            check("f3_x", 32'(eng_x), 32'(i));
        end
        run = 1'b0;
        cyc();
        check("f3_stop", 32'(eng_start), 32'(0));
        eng_done = 4'b0111; out_ready = 1'b1;
        #1 check("f3_valid", 32'(out_valid), 32'(1));
        reset = 1'b1;
        #1 check("rst_cycle_ack", 32'(eng_ack), 32'(0));
        cyc();
        check("rst2_valid", 32'(out_valid), 32'(0));
        check("rst2_start", 32'(eng_start), 32'(0));
        reset = 1'b0;
        cyc();
        check("stale_valid", 32'(out_valid), 32'(0));
        check("stale_ack", 32'(eng_ack), 32'(0));
        eng_done = '0; run = 1'b1;
        cyc();
        check("post_rst_start", 32'(eng_start), 32'(4'b0001));
        check("post_rst_x", 32'(eng_x), 32'(0));
        check("post_rst_y", 32'(eng_y), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
